// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed hex driver for a DIGITS-wide 7-segment display.
// Define SEVEN_SEG_BRIGHTNESS_EN to add the brightness[3:0] on-time control input.
module seven_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  input  logic [3:0]            brightness,
`endif
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [IW-1:0]         digit_idx
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned ON_SPAN = REFRESH_DIV - BLANK_CYCLES;
  localparam int unsigned BLANK_U = BLANK_CYCLES;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0] SEG_OFF = {7{SEG_INV}};
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{DIG_INV}};
  localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      4'hF: hex_to_seg = 7'h71;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  // A digit is blanked while it and every more significant nibble are zero.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v, input logic lz);
    logic zero_run;
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (v[4*i +: 4] == 4'd0);
      lz_mask[i] = lz & zero_run;
    end
  endfunction

  logic [CW-1:0]         cnt_r, cnt_nx_s;
  logic [IW-1:0]         idx_r, idx_nx_s;
  logic                  run_r;
  logic                  slot_start_s, take_s;
  logic [4*DIGITS-1:0]   snap_val_r, val_nx_s;
  logic [DIGITS-1:0]     snap_dp_r, sdp_nx_s;
  logic                  snap_lz_r, lz_nx_s;
  logic [3:0]            bri_nx_s;
  logic [3:0]            nib_s;
  logic [DIGITS-1:0]     mask_s;
  logic [31:0]           on_s;
  logic                  lit_s;
  logic [6:0]            seg_nx_s;
  logic                  dpo_nx_s;
  logic [DIGITS-1:0]     sel_nx_s;
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [DIGITS-1:0]     sel_r;

`ifdef SEVEN_SEG_BRIGHTNESS_EN
  logic [3:0] snap_bri_r;
`endif

  // Slot sequencing: the first enabled cycle restarts at digit 0 with a fresh snapshot.
  always_comb begin
    cnt_nx_s     = cnt_r;
    idx_nx_s     = idx_r;
    slot_start_s = 1'b0;
    take_s       = 1'b0;
    if (!enable) begin
      cnt_nx_s = '0;
      idx_nx_s = '0;
    end else if (!run_r) begin
      cnt_nx_s     = '0;
      idx_nx_s     = '0;
      slot_start_s = 1'b1;
      take_s       = 1'b1;
    end else if (cnt_r == CNT_LAST) begin
      cnt_nx_s     = '0;
      slot_start_s = 1'b1;
      if (idx_r == IDX_LAST) begin
        idx_nx_s = '0;
        take_s   = 1'b1;
      end else begin
        idx_nx_s = idx_r + IW'(1);
      end
    end else begin
      cnt_nx_s = cnt_r + CW'(1);
    end
  end

  // Decode for the upcoming cycle, reading the snapshot as it will be after this edge.
  always_comb begin
    val_nx_s = take_s ? value    : snap_val_r;
    sdp_nx_s = take_s ? dp_in    : snap_dp_r;
    lz_nx_s  = take_s ? lz_blank : snap_lz_r;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    bri_nx_s = take_s ? brightness : snap_bri_r;
`else
    bri_nx_s = 4'hF;
`endif
    nib_s    = val_nx_s[4*int'(idx_nx_s) +: 4];
    mask_s   = lz_mask(val_nx_s, lz_nx_s);
    seg_nx_s = (mask_s[idx_nx_s] ? 7'h00 : hex_to_seg(nib_s)) ^ SEG_OFF;
    dpo_nx_s = sdp_nx_s[idx_nx_s] ^ SEG_INV;
    on_s     = ((32'(bri_nx_s) + 32'd1) * ON_SPAN) >> 4;
    lit_s    = enable && (32'(cnt_nx_s) >= BLANK_U) && (32'(cnt_nx_s) < BLANK_U + on_s);
    if (lit_s) begin
      sel_nx_s = (SEL_ONE << idx_nx_s) ^ SEL_OFF;
    end else begin
      sel_nx_s = SEL_OFF;
    end
  end

  // Counters, snapshot and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= '0;
      idx_r      <= '0;
      run_r      <= 1'b0;
      snap_val_r <= '0;
      snap_dp_r  <= '0;
      snap_lz_r  <= 1'b0;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
      snap_bri_r <= 4'h0;
`endif
      seg_r      <= SEG_OFF;
      dp_r       <= SEG_INV;
      sel_r      <= SEL_OFF;
    end else begin
      cnt_r      <= cnt_nx_s;
      idx_r      <= idx_nx_s;
      run_r      <= enable;
      snap_val_r <= val_nx_s;
      snap_dp_r  <= sdp_nx_s;
      snap_lz_r  <= lz_nx_s;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
      snap_bri_r <= bri_nx_s;
`endif
      sel_r      <= sel_nx_s;
      if (!enable) begin
        seg_r <= SEG_OFF;
        dp_r  <= SEG_INV;
      end else if (slot_start_s) begin
        seg_r <= seg_nx_s;
        dp_r  <= dpo_nx_s;
      end else begin
        seg_r <= seg_r;
        dp_r  <= dp_r;
      end
    end
  end

  assign seg       = seg_r;
  assign dp        = dp_r;
  assign digit_sel = sel_r;
  assign digit_idx = idx_r;

endmodule
